// File: rtl/dmux4way16_stream_pkg.sv
// dmux4way16_stream_pkg: shared constants and channel-state encoding
package dmux4way16_stream_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;
endpackage

// File: rtl/dmux_slot.sv
// dmux_slot: one output channel's holding register, valid flag and delivery counter
module dmux_slot
   import dmux4way16_stream_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             ready,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic             valid,
   output logic [CNT_W-1:0] cnt
);
   ch_state_t state;
   logic      deliver;
   assign valid   = state == FULL;
   assign deliver = valid && ready;
   // a load refills the slot even while it delivers; otherwise a delivery empties it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= EMPTY;
         q     <= '0;
         cnt   <= '0;
      end else begin
         if (load) begin
            state <= FULL;
            q     <= data;
         end else if (deliver)
            state <= EMPTY;
         cnt <= clr ? '0 : cnt + CNT_W'(deliver);
      end
endmodule

// File: rtl/dmux4way16_stream.sv
// dmux4way16_stream: registered 4-way stream demultiplexer with per-channel delivery counters
module dmux4way16_stream
   import dmux4way16_stream_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [SEL_W-1:0]  in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WIDTH-1:0]  out_data0,
   output logic [WIDTH-1:0]  out_data1,
   output logic [WIDTH-1:0]  out_data2,
   output logic [WIDTH-1:0]  out_data3,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1,
   output logic [CNT_W-1:0]  cnt2,
   output logic [CNT_W-1:0]  cnt3
);
   logic [WIDTH-1:0] q [NUM_CH];
   logic [CNT_W-1:0] c [NUM_CH];
   logic             accept;
   assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
   assign accept   = in_valid && in_ready;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      dmux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (accept && in_sel == SEL_W'(i)),
         .data  (in_data),
         .ready (out_ready[i]),
         .clr   (cnt_clr),
         .q     (q[i]),
         .valid (out_valid[i]),
         .cnt   (c[i])
      );
   end
   assign out_data0 = q[0];
   assign out_data1 = q[1];
   assign out_data2 = q[2];
   assign out_data3 = q[3];
   assign cnt0      = c[0];
   assign cnt1      = c[1];
   assign cnt2      = c[2];
   assign cnt3      = c[3];
endmodule

// File: tb/tb_dmux4way16_stream.sv
// tb_dmux4way16_stream: directed and random checks against a channel-level reference model
module tb_dmux4way16_stream;
   logic        clk = 0;
   logic        rst_n = 0;
   logic [15:0] in_data = 0;
   logic [1:0]  in_sel = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [15:0] out_data0, out_data1, out_data2, out_data3;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = 0;
   logic        cnt_clr = 0;
   logic [7:0]  cnt0, cnt1, cnt2, cnt3;
   logic [15:0] od [4];
   logic [7:0]  oc [4];
   int          passed = 0;
   int          total = 0;
   bit          m_full [4];
   logic [15:0] m_data [4];
   int          m_cnt [4];

   assign od[0] = out_data0;
   assign od[1] = out_data1;
   assign od[2] = out_data2;
   assign od[3] = out_data3;
   assign oc[0] = cnt0;
   assign oc[1] = cnt1;
   assign oc[2] = cnt2;
   assign oc[3] = cnt3;

   always #5 clk = ~clk;

   dmux4way16_stream dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
      .out_data3(out_data3), .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
      .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_full[i] = 0;
         m_data[i] = 0;
         m_cnt[i]  = 0;
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d,
                        input logic [3:0] r, input logic c);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      cnt_clr   = c;
   endtask

   task automatic compare_all();
      logic [3:0] mv;
      for (int i = 0; i < 4; i++) mv[i] = m_full[i];
      check("out_valid", out_valid, mv);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("out_data%0d", i), od[i], m_data[i]);
         check($sformatf("cnt%0d", i), oc[i], m_cnt[i] % 256);
      end
   endtask

   // one clock: check in_ready, advance the model across the edge, compare everything after it
   task automatic cyc();
      bit exp_rdy, acc;
      #1;
      exp_rdy = !m_full[in_sel] || out_ready[in_sel];
      check("in_ready", in_ready, exp_rdy);
      acc = in_valid && exp_rdy;
      for (int i = 0; i < 4; i++) begin
         if (m_full[i] && out_ready[i]) begin
            m_cnt[i] = m_cnt[i] + 1;
            m_full[i] = 0;
         end
         if (cnt_clr) m_cnt[i] = 0;
      end
      if (acc) begin
         m_full[in_sel] = 1;
         m_data[in_sel] = in_data;
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", out_valid, 4'b0000);
      rst_n = 1;
      #1;
      compare_all();
      check("reset_in_ready", in_ready, 1'b1);

      // basic route
      drive(1, 1, 16'hA5A5, 4'b0000, 0); cyc();
      check("route_valid", out_valid, 4'b0010);
      check("route_data1", out_data1, 16'hA5A5);
      drive(0, 0, 16'h0, 4'b0010, 0); cyc();
      check("route_drain", out_valid, 4'b0000);
      check("route_cnt1", cnt1, 8'd1);

      // backpressure on channel 3
      drive(1, 3, 16'h1234, 4'b0000, 0); cyc();
      drive(1, 3, 16'h5678, 4'b0000, 0);
      #1 check("bp_stall_rdy", in_ready, 1'b0);
      cyc();
      check("bp_hold", out_data3, 16'h1234);
      drive(1, 3, 16'h5678, 4'b1000, 0);
      #1 check("bp_release_rdy", in_ready, 1'b1);
      cyc();
      check("bp_new", out_data3, 16'h5678);
      check("bp_valid3", out_valid[3], 1'b1);

      // independence: channel 0 stalled, channel 2 streams
      drive(1, 0, 16'hBEEF, 4'b0000, 0); cyc();
      for (int w = 1; w <= 3; w++) begin
         drive(1, 2, 16'(w), 4'b0100, 0);
         #1 check("ind_rdy", in_ready, 1'b1);
         cyc();
         check("ind_data2", out_data2, 16'(w));
      end
      drive(0, 0, 16'h0, 4'b0100, 0); cyc();
      check("ind_cnt2", cnt2, 8'd3);
      check("ind_data0", out_data0, 16'hBEEF);
      check("ind_valid0", out_valid[0], 1'b1);

      // drain everything and clear counters
      drive(0, 0, 16'h0, 4'b1111, 1); cyc();
      check("clr_all", {cnt0, cnt1, cnt2, cnt3}, 32'h0);

      // full throughput on channel 0
      for (int k = 1; k <= 8; k++) begin
         drive(1, 0, 16'h100 + 16'(k), 4'b0001, 0);
         #1 check("tp_rdy", in_ready, 1'b1);
         cyc();
         check("tp_valid0", out_valid[0], 1'b1);
         check("tp_data0", out_data0, 16'h100 + 16'(k));
      end
      drive(0, 0, 16'h0, 4'b0001, 0); cyc();
      check("tp_cnt0", cnt0, 8'd8);

      // 256 deliveries on channel 1 wrap its counter to zero
      drive(0, 0, 16'h0, 4'b0000, 1); cyc();
      for (int k = 0; k < 256; k++) begin
         drive(1, 1, 16'(k), 4'b0010, 0); cyc();
      end
      drive(0, 0, 16'h0, 4'b0010, 0); cyc();
      check("wrap_cnt1", cnt1, 8'd0);

      // clear wins over a simultaneous delivery
      drive(1, 0, 16'h4242, 4'b0000, 0); cyc();
      drive(0, 0, 16'h0, 4'b0001, 0); cyc();
      check("pre_clr_cnt0", cnt0, 8'd1);
      drive(1, 0, 16'h4343, 4'b0000, 0); cyc();
      drive(0, 0, 16'h0, 4'b0001, 1); cyc();
      check("clr_prio_cnt0", cnt0, 8'd0);

      // random traffic
      for (int k = 0; k < 600; k++) begin
         drive(1'($urandom), 2'($urandom), 16'($urandom), 4'($urandom),
               $urandom_range(0, 31) == 0);
         cyc();
      end

      // asynchronous reset mid-cycle with channel 2 full
      drive(1, 2, 16'hCAFE, 4'b0000, 0); cyc();
      drive(0, 0, 16'h0, 4'b0000, 0);
      check("pre_rst_valid2", out_valid[2], 1'b1);
      #2 rst_n = 0;
      #1;
      check("rst_valid", out_valid, 4'b0000);
      check("rst_data2", out_data2, 16'h0);
      check("rst_cnt2", cnt2, 8'd0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1;
      compare_all();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dmux4way16_stream.md
Name: dmux4way16_stream

Overview:
Registered 4-way 16-bit stream demultiplexer, the inverse of the 4-way 16-bit mux.
- A single valid/ready input channel carries a word plus a 2-bit select.
- Each word is routed into a one-entry holding register on one of four output channels, each with its own valid/ready handshake.
- Per-channel delivery counters support bring-up and verification.
- Sits between a single producer and up to four independent consumers.

Parameters:
WIDTH, 16, data word width in bits
CNT_W, 8, width of each per-channel delivery counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  input word
in_sel  input  2  destination channel for in_data (0..3)
in_valid  input  1  producer has a word on in_data/in_sel
in_ready  output  1  block accepts the word this cycle
out_data0  output  WIDTH  channel 0 held word
out_data1  output  WIDTH  channel 1 held word
out_data2  output  WIDTH  channel 2 held word
out_data3  output  WIDTH  channel 3 held word
out_valid  output  4  bit i: channel i holding register is full
out_ready  input  4  bit i: consumer i takes the word this cycle
cnt_clr  input  1  synchronous clear of all delivery counters
cnt0  output  CNT_W  words delivered on channel 0
cnt1  output  CNT_W  words delivered on channel 1
cnt2  output  CNT_W  words delivered on channel 2
cnt3  output  CNT_W  words delivered on channel 3

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately forces out_valid=4'b0000, all out_dataN=0 and all cntN=0. Any buffered words are discarded.
- Reset asserted mid-transfer loses the buffered word. No partial state survives.
- Per-channel state machine, channel i:
  - EMPTY: out_valid[i]=0.
  - FULL: out_valid[i]=1.
- in_ready is combinational: in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - in_ready depends only on the selected channel.
  - in_ready does not depend on in_valid.
- Accept: in_valid && in_ready. On the next edge, in_data is loaded into holding register in_sel and out_valid[in_sel]=1.
- Latency is exactly 1 cycle from accept to out_valid.
- Deliver on channel i: out_valid[i] && out_ready[i] at a rising edge.
  - If no accept targets i on the same edge: channel i goes EMPTY and out_dataN keeps its last value.
  - If an accept targets i on the same edge: channel i stays FULL with the new word. Full throughput is one word per cycle per channel.
- The four channels are independent. A stalled channel (FULL, out_ready=0) blocks only inputs selected to it; words for other channels still flow.
- in_sel and in_data matter only when in_valid=1. out_dataN is held stable while out_valid[N]=1 and no deliver occurs.
- The producer must hold in_data/in_sel stable while in_valid=1 && in_ready=0. The block does not check this.
- Counters:
  - cntN increments by 1 on each deliver of channel N.
  - Wraps modulo 2^CNT_W (255 -> 0 at default).
  - cnt_clr=1 zeroes all counters on the next edge and takes priority over a simultaneous increment.
- All 4 in_sel codes are legal. There is no error state.

Decomposition:
- Shared package holds:
  - NUM_CH = 4.
  - SEL_W = 2.
  - Channel-state encoding: EMPTY = 1'b0, FULL = 1'b1.
- One sub-module, dmux_slot: a single channel's holding register, valid flag and delivery counter.
  - Inputs: load, data, ready, clr.
  - Instantiated 4 times.
- The top contains only the select decode and the in_ready mux.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with channel 2 FULL -> out_valid=0000, out_data2=0, cnt2=0 immediately, without waiting for a clock edge.
- Basic route: in_valid=1, in_sel=1, in_data=16'hA5A5, out_ready=0000, one cycle -> next cycle out_valid=0010 and out_data1=A5A5. Then out_ready[1]=1 for one cycle -> out_valid=0000 and cnt1=1.
- Backpressure: channel 3 FULL holding 16'h1234, out_ready[3]=0, present in_sel=3 with data 16'h5678 -> in_ready=0 and out_data3 stays 1234. Raise out_ready[3] -> in_ready=1 same cycle; next cycle out_data3=5678, out_valid[3]=1.
- Independence: channel 0 stalled FULL, stream sel=2 words 1,2,3 with out_ready[2]=1 -> all accepted back-to-back, cnt2 reaches 3, channel 0 unchanged.
- Throughput: stream 8 words to sel=0 with out_ready[0]=1 continuously -> in_ready stays 1 and out_valid[0] stays 1 from cycle 1 through cycle 8. Words appear in order one cycle after accept and cnt0=8.
- Counter wrap/clear: 256 deliveries on channel 1 -> cnt1=0. Assert cnt_clr in the same cycle as a channel 0 deliver -> cnt0=0 next cycle.
